// File: rtl/fetch_controller_pkg.sv
// Shared types and default constants for the instruction fetch controller.
package fetch_pkg;

   // Fetch sequencing states.
   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_REQ  = 2'd1,
      FS_WAIT = 2'd2,
      FS_HOLD = 2'd3
   } fetch_state_t;

   // Next-PC source chosen by the FSM each cycle.
   typedef enum logic [1:0] {
      PC_SEL_HOLD     = 2'd0,
      PC_SEL_STEP     = 2'd1,
      PC_SEL_REDIRECT = 2'd2
   } pc_sel_t;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam int unsigned PC_STEP_DEFAULT      = 32'd4;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory request/response channel between fetch and memory.
interface fetch_controller_if #(
   parameter int XLEN = 32
) ();
   logic            req;
   logic [XLEN-1:0] addr;
   logic            ready;
   logic            valid;
   logic [XLEN-1:0] rdata;

   modport master (output req, output addr, input ready, input valid, input rdata);
   modport slave  (input req, input addr, output ready, output valid, output rdata);
endinterface

// File: rtl/fetch_controller_pc_reg.sv
// Program counter register with reset / redirect / step / hold next-value mux.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
   parameter int unsigned     PC_STEP      = PC_STEP_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  pc_sel_t         pc_sel,
   input  logic [XLEN-1:0] redirect_target,
   output logic [XLEN-1:0] pc
);

   logic [XLEN-1:0] pc_r;

   // Redirect targets are word aligned by clearing the two low bits.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
      return a & {{(XLEN-2){1'b1}}, 2'b00};
   endfunction

   // PC update; the step wraps naturally modulo 2^XLEN.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r <= RESET_VECTOR;
      end else begin
         case (pc_sel)
            PC_SEL_HOLD:     pc_r <= pc_r;
            PC_SEL_STEP:     pc_r <= pc_r + XLEN'(PC_STEP);
            PC_SEL_REDIRECT: pc_r <= align_word(redirect_target);
            default:         pc_r <= pc_r;
         endcase
      end
   end

   assign pc = pc_r;

endmodule

// File: rtl/fetch_controller.sv
// Fetch controller: one outstanding instruction-memory request at a time,
// holds each fetched word for decode, and lets execute redirect the PC.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
   parameter int unsigned     PC_STEP      = PC_STEP_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   fetch_controller_if.master imem,
   output logic              instr_valid,
   output logic [XLEN-1:0]   instr,
   output logic [XLEN-1:0]   instr_pc,
   input  logic              decode_ready,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_target,
   output logic [XLEN-1:0]   pc_out
);

   fetch_state_t    state_r;
   pc_sel_t         pc_sel_s;
   logic [XLEN-1:0] pc_s;
   logic            kill_r;
   logic            req_r;
   logic            instr_valid_r;
   logic [XLEN-1:0] instr_r;
   logic [XLEN-1:0] instr_pc_r;

   fetch_pc_reg #(
      .XLEN         (XLEN),
      .RESET_VECTOR (RESET_VECTOR),
      .PC_STEP      (PC_STEP)
   ) u_pc_reg (
      .clk             (clk),
      .rst             (rst),
      .pc_sel          (pc_sel_s),
      .redirect_target (redirect_target),
      .pc              (pc_s)
   );

   // Next-PC source: redirect wins everywhere; step only on a kept response.
   always_comb begin
      pc_sel_s = PC_SEL_HOLD;
      case (state_r)
         FS_IDLE, FS_REQ, FS_HOLD: begin
            if (redirect_valid) pc_sel_s = PC_SEL_REDIRECT;
            else                pc_sel_s = PC_SEL_HOLD;
         end
         FS_WAIT: begin
            if (redirect_valid)              pc_sel_s = PC_SEL_REDIRECT;
            else if (imem.valid && !kill_r)  pc_sel_s = PC_SEL_STEP;
            else                             pc_sel_s = PC_SEL_HOLD;
         end
         default: pc_sel_s = PC_SEL_HOLD;
      endcase
   end

   // Fetch FSM with registered request, kill flag and instruction buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= FS_IDLE;
         req_r         <= 1'b0;
         kill_r        <= 1'b0;
         instr_valid_r <= 1'b0;
         instr_r       <= '0;
         instr_pc_r    <= '0;
      end else begin
         case (state_r)
            FS_IDLE: begin
               state_r <= FS_REQ;
               req_r   <= 1'b1;
            end
            FS_REQ: begin
               if (imem.ready) begin
                  // A redirect in the accept cycle leaves the old-PC response in flight.
                  state_r <= FS_WAIT;
                  req_r   <= 1'b0;
                  kill_r  <= redirect_valid;
               end else begin
                  state_r <= FS_REQ;
                  req_r   <= 1'b1;
               end
            end
            FS_WAIT: begin
               if (imem.valid) begin
                  if (kill_r || redirect_valid) begin
                     state_r <= FS_REQ;
                     req_r   <= 1'b1;
                     kill_r  <= 1'b0;
                  end else begin
                     state_r       <= FS_HOLD;
                     req_r         <= 1'b0;
                     kill_r        <= 1'b0;
                     instr_r       <= imem.rdata;
                     instr_pc_r    <= pc_s;
                     instr_valid_r <= 1'b1;
                  end
               end else begin
                  state_r <= FS_WAIT;
                  req_r   <= 1'b0;
                  if (redirect_valid) kill_r <= 1'b1;
                  else                kill_r <= kill_r;
               end
            end
            FS_HOLD: begin
               if (redirect_valid || decode_ready) begin
                  state_r       <= FS_REQ;
                  req_r         <= 1'b1;
                  instr_valid_r <= 1'b0;
               end else begin
                  state_r <= FS_HOLD;
                  req_r   <= 1'b0;
               end
            end
            default: begin
               state_r       <= FS_IDLE;
               req_r         <= 1'b0;
               kill_r        <= 1'b0;
               instr_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign imem.req    = req_r;
   assign imem.addr   = pc_s;
   assign pc_out      = pc_s;
   assign instr_valid = instr_valid_r;
   assign instr       = instr_r;
   assign instr_pc    = instr_pc_r;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: a scoreboard queue holds the
// expected (pc, word) of every fetch the bench lets through, and a monitor
// compares each newly presented instruction against the head of the queue.
module tb_fetch_controller;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } sb_item_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        decode_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc_out;
   logic        prev_valid;

   sb_item_t sb_q[$];
   int       n_checks = 0;
   int       n_fail   = 0;

   fetch_controller_if #(.XLEN(32)) imem_if ();

   fetch_controller dut (
      .clk             (clk),
      .rst             (rst),
      .imem            (imem_if),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .decode_ready    (decode_ready),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .pc_out          (pc_out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Memory contents model: a word derived from its address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_req();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (imem_if.req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check_eq("req_timeout", {31'd0, imem_if.req}, 32'd1);
   endtask

   // Zero-wait fetch: ready one cycle, response the next; expected pushed to scoreboard.
   task automatic fetch_one(input logic [31:0] addr);
      sb_item_t it;
      wait_req();
      check_eq("req_addr", imem_if.addr, addr);
      it.pc   = addr;
      it.data = mem_word(addr);
      sb_q.push_back(it);
      imem_if.ready = 1'b1;
      step();
      imem_if.ready = 1'b0;
      imem_if.valid = 1'b1;
      imem_if.rdata = mem_word(addr);
      step();
      imem_if.valid = 1'b0;
      imem_if.rdata = 32'h0000_0000;
   endtask

   // Scoreboard monitor: every newly presented instruction must match the queue head.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid <= 1'b0;
      end else begin
         if (instr_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
               sb_item_t it;
               it = sb_q.pop_front();
               check_eq("sb_instr_pc", instr_pc, it.pc);
               check_eq("sb_instr", instr, it.data);
            end
         end
         prev_valid <= instr_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      decode_ready    = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0000_0000;
      imem_if.ready   = 1'b0;
      imem_if.valid   = 1'b0;
      imem_if.rdata   = 32'h0000_0000;
      repeat (3) step();
      rst = 1'b0;

      // Reset state (cycle 0, FS_IDLE)
      check_eq("rst_pc", pc_out, 32'h0000_0000);
      check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("rst_req", {31'd0, imem_if.req}, 32'd0);
      check_eq("rst_instr", instr, 32'h0000_0000);
      check_eq("rst_instr_pc", instr_pc, 32'h0000_0000);

      // Sequential fetches
      fetch_one(32'h0000_0000);
      fetch_one(32'h0000_0004);
      fetch_one(32'h0000_0008);
      step();

      // Decode stall: buffer must stay stable, no new request
      decode_ready = 1'b0;
      fetch_one(32'h0000_000C);
      for (int i = 0; i < 5; i++) begin
         check_eq("hold_valid", {31'd0, instr_valid}, 32'd1);
         check_eq("hold_instr", instr, mem_word(32'h0000_000C));
         check_eq("hold_pc", instr_pc, 32'h0000_000C);
         check_eq("hold_no_req", {31'd0, imem_if.req}, 32'd0);
         step();
      end
      decode_ready = 1'b1;

      // Redirect during FS_WAIT; late response must be discarded
      wait_req();
      check_eq("w_req_addr", imem_if.addr, 32'h0000_0010);
      imem_if.ready = 1'b1;
      step();
      imem_if.ready   = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0100;
      step();
      redirect_valid = 1'b0;
      check_eq("w_pc_redirect", pc_out, 32'h0000_0100);
      check_eq("w_no_req", {31'd0, imem_if.req}, 32'd0);
      step();
      imem_if.valid = 1'b1;
      imem_if.rdata = 32'hDEAD_BEEF;
      step();
      imem_if.valid = 1'b0;
      check_eq("w_req_after", {31'd0, imem_if.req}, 32'd1);
      check_eq("w_addr_after", imem_if.addr, 32'h0000_0100);
      fetch_one(32'h0000_0100);

      // Redirect coinciding with request accept; target alignment
      wait_req();
      check_eq("r_req_addr", imem_if.addr, 32'h0000_0104);
      imem_if.ready   = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0203;
      step();
      imem_if.ready  = 1'b0;
      redirect_valid = 1'b0;
      check_eq("r_pc_aligned", pc_out, 32'h0000_0200);
      imem_if.valid = 1'b1;
      imem_if.rdata = 32'h1234_5678;
      step();
      imem_if.valid = 1'b0;
      check_eq("r_req_after", {31'd0, imem_if.req}, 32'd1);
      check_eq("r_addr_after", imem_if.addr, 32'h0000_0200);
      fetch_one(32'h0000_0200);

      // Redirect to top of address space; step wraps to zero
      wait_req();
      check_eq("x_req_addr", imem_if.addr, 32'h0000_0204);
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      check_eq("x_pc_top", pc_out, 32'hFFFF_FFFC);
      fetch_one(32'hFFFF_FFFC);
      fetch_one(32'h0000_0000);

      // Reset while waiting; stale response after reset is ignored
      wait_req();
      check_eq("z_req_addr", imem_if.addr, 32'h0000_0004);
      imem_if.ready = 1'b1;
      step();
      imem_if.ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      imem_if.valid = 1'b1;
      imem_if.rdata = 32'hBAD0_BAD0;
      check_eq("z_valid_idle", {31'd0, instr_valid}, 32'd0);
      check_eq("z_pc_idle", pc_out, 32'h0000_0000);
      check_eq("z_req_idle", {31'd0, imem_if.req}, 32'd0);
      step();
      imem_if.valid = 1'b0;
      check_eq("z_valid_req", {31'd0, instr_valid}, 32'd0);
      check_eq("z_req", {31'd0, imem_if.req}, 32'd1);
      check_eq("z_addr", imem_if.addr, 32'h0000_0000);
      fetch_one(32'h0000_0000);
      fetch_one(32'h0000_0004);
      repeat (3) step();

      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
